adc_sclk_cs_gen: RTL

- Timing master for the serial ADC front end. Generates the conversion framing (CS), the serial clock (SCLK) and the receive enable (rx_en) consumed by the ADC receive stage.
- Divides the system clock into a fixed sample rate (default 40 kHz at 100 MHz) and produces exactly one frame of FRAME_BITS+1 SCLK falling edges per sample. The extra edge clocks the receiver's load/done cycle.
- Sits directly upstream of the ADC receiver. Its CS/SCLK pins also drive the external ADC.

---
 rtl/adc_pkg.sv | 8 +
 rtl/adc_sclk_cs_gen_if.sv | 12 +
 rtl/adc_tick_gen.sv | 31 +++
 rtl/adc_sclk_cs_gen.sv | 88 ++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared constants and state encoding for the serial ADC front end
package adc_pkg;
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;
  localparam int ADC_SCLK_HALF  = 2;
  localparam int ADC_SAMPLE_DIV = 2500;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2} state_t;
endpackage

// File: rtl/adc_sclk_cs_gen_if.sv
// adc_sclk_cs_gen_if: enable input and framing outputs of the ADC timing master
interface adc_sclk_cs_gen_if;
  logic en;
  logic CS;
  logic SCLK;
  logic rx_en;
  logic frame_start;
  logic frame_done;
  logic busy;
  modport master (input en, output CS, SCLK, rx_en, frame_start, frame_done, busy);
  modport slave (output en, input CS, SCLK, rx_en, frame_start, frame_done, busy);
endinterface

// File: rtl/adc_tick_gen.sv
// adc_tick_gen: sample-rate divider, registered tick SAMPLE_DIV clks after en is first sampled
module adc_tick_gen
  import adc_pkg::*;
#(
  parameter int SAMPLE_DIV = ADC_SAMPLE_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(SAMPLE_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          wrap;
  assign wrap = cnt_q == CW'(SAMPLE_DIV - 1);
  always_comb begin
    cnt_d  = en ? (wrap ? '0 : cnt_q + 1'b1) : '0;
    tick_d = en & wrap;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end
  assign tick = tick_q;
endmodule

// File: rtl/adc_sclk_cs_gen.sv
// adc_sclk_cs_gen: CS/SCLK/rx_en framing for the serial ADC, one frame of FRAME_BITS+1
// falling SCLK edges per sample tick.
module adc_sclk_cs_gen
  import adc_pkg::*;
#(
  parameter int SCLK_HALF  = ADC_SCLK_HALF,
  parameter int FRAME_BITS = ADC_FRAME_BITS,
  parameter int SAMPLE_DIV = ADC_SAMPLE_DIV
) (
  input logic               clk,
  input logic               reset,
  adc_sclk_cs_gen_if.master bus
);
  localparam int HW = $clog2(SCLK_HALF + 1);
  localparam int EW = $clog2(FRAME_BITS + 2);
  if (SCLK_HALF < 1) begin : g_bad_half
    $fatal(1, "adc_sclk_cs_gen: SCLK_HALF must be >= 1");
  end
  if (SAMPLE_DIV < 2 * SCLK_HALF * (FRAME_BITS + 2)) begin : g_bad_div
    $fatal(1, "adc_sclk_cs_gen: SAMPLE_DIV too small for one frame");
  end
  state_t        state_q, state_d;
  logic [HW-1:0] hc_q, hc_d;
  logic [EW-1:0] ec_q, ec_d;
  logic          cs_q, cs_d, sclk_q, sclk_d, start_q, start_d, done_q, done_d;
  logic          tick, hc_wrap, last_edge;
  adc_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (bus.en),
    .tick (tick)
  );
  assign hc_wrap   = hc_q == HW'(SCLK_HALF - 1);
  assign last_edge = ec_q == EW'(FRAME_BITS + 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hc_q    <= '0;
      ec_q    <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      ec_q    <= ec_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    hc_d    = hc_wrap ? '0 : hc_q + 1'b1;
    ec_d    = ec_q;
    case (state_q)
      IDLE: begin
        hc_d = '0;
        ec_d = '0;
        if (tick && bus.en) state_d = SETUP;
      end
      SETUP: if (hc_wrap) begin
        state_d = SHIFT;
        ec_d    = EW'(1);
      end
      SHIFT: begin
        // sclk_q high at wrap means this wrap is a falling edge
        if (hc_wrap && sclk_q) ec_d = ec_q + 1'b1;
        if (hc_wrap && !sclk_q && last_edge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cs_d    = state_d == IDLE;
    sclk_d  = (state_d != SHIFT) ? 1'b1 : (hc_wrap ? ~sclk_q : sclk_q);
    start_d = state_q == IDLE && state_d == SETUP;
    done_d  = state_q == SHIFT && state_d == IDLE;
  end
  assign bus.CS          = cs_q;
  assign bus.SCLK        = sclk_q;
  assign bus.rx_en       = ~cs_q;
  assign bus.busy        = ~cs_q;
  assign bus.frame_start = start_q;
  assign bus.frame_done  = done_q;
endmodule
